// File: rtl/dmem_responder_if.sv
// Load/store port bundle between the core MEM stage and the data memory.
// Request: req_valid/req_ready/req_we/req_addr/req_wdata/req_funct3.
// Response: rsp_valid/rsp_ready/rsp_rdata/rsp_err.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle RV32I data-memory responder, one transaction in flight.
// Ports: clk, rst (sync, active-high), bus (dmem_responder_if.slave).
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nxt;

    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    logic              accept;
    logic              commit;
    logic [ADDR_W-1:0] widx;
    logic [1:0]        lane;
    logic [31:0]       shifted;
    logic              f3_ok;
    logic              misal;
    logic              oor;
    logic              err;
    logic [31:0]       ld;
    logic [31:0]       rdata;
    logic [3:0]        be;
    logic [31:0]       wrep;

    assign accept = (state == IDLE) && bus.req_valid;
    assign commit = (state == WAIT) && (cnt == 4'd0);

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (commit) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign widx    = addr_q[ADDR_W+1:2];
    assign lane    = addr_q[1:0];
    // Selected lane(s) end up right-aligned; legal halves have lane[0]=0.
    assign shifted = mem[widx] >> {lane, 3'b000};

    always_comb begin
        if (we_q)
            f3_ok = f3_q inside {3'b000, 3'b001, 3'b010};
        else
            f3_ok = f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        misal = ((f3_q[1:0] == 2'b01) && lane[0])
              || ((f3_q[1:0] == 2'b10) && (lane != 2'b00));
        oor   = |addr_q[31:ADDR_W+2];
        err   = !f3_ok || misal || oor;
    end

    always_comb begin
        ld = 32'd0;
        unique case (f3_q)
            3'b000:  ld = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ld = {24'd0, shifted[7:0]};
            3'b001:  ld = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ld = {16'd0, shifted[15:0]};
            3'b010:  ld = shifted;
            default: ld = 32'd0;
        endcase
        rdata = (we_q || err) ? 32'd0 : ld;
    end

    // Store data is replicated across lanes so the byte enables alone
    // pick which lanes change.
    always_comb begin
        be   = 4'b1111;
        wrep = wdata_q;
        unique case (f3_q[1:0])
            2'b00: begin
                be   = 4'b0001 << lane;
                wrep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be   = 4'b0011 << {lane[1], 1'b0};
                wrep = {2{wdata_q[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wrep = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                f3_q    <= bus.req_funct3;
                cnt     <= 4'(LATENCY - 1);
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rdata_q <= rdata;
                err_q   <= err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && we_q && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wrep[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a response scoreboard.
// Runs a LATENCY=2 instance for most steps and a LATENCY=1 instance.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   lat;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    dmem_responder_if b2();
    dmem_responder_if b1();

    dmem_responder #(.DEPTH(64), .ADDR_W(6), .LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .bus(b2)
    );
    dmem_responder #(.DEPTH(64), .ADDR_W(6), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f,
                        input logic push, input logic e,
                        input logic [31:0] x);
        int n;
        if (push) sb.push_back({e, x});
        b2.req_valid  = 1'b1;
        b2.req_we     = we;
        b2.req_addr   = a;
        b2.req_wdata  = d;
        b2.req_funct3 = f;
        n = 0;
        while (!b2.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 32'(b2.req_ready), 32'd1);
        @(negedge clk);
        b2.req_valid = 1'b0;
        lat = 0;
    endtask

    task automatic wait_rsp();
        logic [32:0] e;
        while (!b2.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd2);
        e = (sb.size() > 0) ? sb.pop_front() : '1;
        chk("rdata", b2.rsp_rdata, e[31:0]);
        chk("err", 32'(b2.rsp_err), 32'(e[32]));
    endtask

    task automatic ack();
        b2.rsp_ready = 1'b1;
        @(negedge clk);
        b2.rsp_ready = 1'b0;
        chk("rsp_drop", 32'(b2.rsp_valid), 32'd0);
        chk("ready_back", 32'(b2.req_ready), 32'd1);
    endtask

    task automatic xact(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f,
                        input logic e, input logic [31:0] x);
        send(we, a, d, f, 1'b1, e, x);
        wait_rsp();
        ack();
    endtask

    initial begin
        rst = 1'b1;
        b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = '0;
        b2.req_wdata = '0;   b2.req_funct3 = '0; b2.rsp_ready = 1'b0;
        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = '0;
        b1.req_wdata = '0;   b1.req_funct3 = '0; b1.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", 32'(b2.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(b2.rsp_valid), 32'd0);
        chk("rst_rdata", b2.rsp_rdata, 32'd0);
        chk("rst_err", 32'(b2.rsp_err), 32'd0);

        xact(1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 32'h0);

        xact(1, 32'h10, 32'h0, 3'b010, 0, 32'h0);
        xact(1, 32'h13, 32'hA5, 3'b000, 0, 32'h0);
        xact(0, 32'h10, 32'h0, 3'b010, 0, 32'hA5000000);
        xact(0, 32'h13, 32'h0, 3'b000, 0, 32'hFFFFFFA5);
        xact(0, 32'h13, 32'h0, 3'b100, 0, 32'h000000A5);

        xact(1, 32'h20, 32'h11223344, 3'b010, 0, 32'h0);
        xact(1, 32'h22, 32'h00008001, 3'b001, 0, 32'h0);
        xact(0, 32'h22, 32'h0, 3'b001, 0, 32'hFFFF8001);
        xact(0, 32'h22, 32'h0, 3'b101, 0, 32'h00008001);
        xact(0, 32'h20, 32'h0, 3'b010, 0, 32'h80013344);

        xact(0, 32'h12, 32'h0, 3'b010, 1, 32'h0);
        xact(1, 32'h21, 32'hFFFF, 3'b001, 1, 32'h0);
        xact(0, 32'h20, 32'h0, 3'b010, 0, 32'h80013344);
        xact(0, 32'h100, 32'h0, 3'b010, 1, 32'h0);
        xact(0, 32'h10, 32'h0, 3'b011, 1, 32'h0);
        xact(1, 32'h10, 32'h77, 3'b100, 1, 32'h0);
        xact(0, 32'h10, 32'h0, 3'b010, 0, 32'hA5000000);

        send(0, 32'h10, 32'h0, 3'b010, 1, 0, 32'hA5000000);
        wait_rsp();
        sb.push_back({1'b0, 32'h80013344});
        b2.req_valid  = 1'b1;
        b2.req_we     = 1'b0;
        b2.req_addr   = 32'h20;
        b2.req_funct3 = 3'b010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(b2.rsp_valid), 32'd1);
            chk("bp_rdata", b2.rsp_rdata, 32'hA5000000);
            chk("bp_req_ready", 32'(b2.req_ready), 32'd0);
        end
        b2.rsp_ready = 1'b1;
        @(negedge clk);
        b2.rsp_ready = 1'b0;
        chk("bp_drop", 32'(b2.rsp_valid), 32'd0);
        chk("bp_idle", 32'(b2.req_ready), 32'd1);
        @(negedge clk);
        b2.req_valid = 1'b0;
        chk("bp_taken", 32'(b2.req_ready), 32'd0);
        lat = 0;
        wait_rsp();
        ack();

        xact(1, 32'h30, 32'hCAFEF00D, 3'b010, 0, 32'h0);
        send(1, 32'h30, 32'h12345678, 3'b010, 0, 0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", 32'(b2.req_ready), 32'd1);
        chk("mid_rst_valid", 32'(b2.rsp_valid), 32'd0);
        xact(0, 32'h30, 32'h0, 3'b010, 0, 32'hCAFEF00D);

        b1.req_valid  = 1'b1;
        b1.req_we     = 1'b1;
        b1.req_addr   = 32'h4;
        b1.req_wdata  = 32'hC3;
        b1.req_funct3 = 3'b010;
        chk("l1_ready", 32'(b1.req_ready), 32'd1);
        @(negedge clk);
        b1.req_valid = 1'b0;
        chk("l1_early", 32'(b1.rsp_valid), 32'd0);
        @(negedge clk);
        chk("l1_valid", 32'(b1.rsp_valid), 32'd1);
        chk("l1_st_rdata", b1.rsp_rdata, 32'd0);
        chk("l1_st_err", 32'(b1.rsp_err), 32'd0);
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        b1.rsp_ready = 1'b0;
        chk("l1_drop", 32'(b1.rsp_valid), 32'd0);
        b1.req_valid  = 1'b1;
        b1.req_we     = 1'b0;
        b1.req_funct3 = 3'b000;
        chk("l1_ready2", 32'(b1.req_ready), 32'd1);
        @(negedge clk);
        b1.req_valid = 1'b0;
        @(negedge clk);
        chk("l1_ld_valid", 32'(b1.rsp_valid), 32'd1);
        chk("l1_ld_rdata", b1.rsp_rdata, 32'hFFFFFFC3);
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        b1.rsp_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
